// File: rtl/qpu_ift2itcm_pkg.sv
// qpu_ift2itcm_pkg: shared defaults and helpers for the IFU-to-ITCM fetch bridge
package qpu_ift2itcm_pkg;
  localparam int          ITCM_AW_DEF   = 12;
  localparam logic [31:0] ITCM_BASE_DEF = 32'h0000_0000;
  localparam int          RD_LAT_DEF    = 1;
  localparam int          PERF_W        = 16;
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/qpu_ift2itcm_rspbuf.sv
// qpu_ift2itcm_rspbuf: 2-entry {err, instr} response FIFO with occupancy count
module qpu_ift2itcm_rspbuf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         push_err,
  input  logic [W-1:0] push_instr,
  input  logic         pop,
  output logic         head_err,
  output logic [W-1:0] head_instr,
  output logic [1:0]   cnt
);
  logic [W:0] mem [2];
  logic       wptr, rptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) mem[wptr] <= {push_err, push_instr};
      wptr <= wptr ^ push;
      rptr <= rptr ^ pop;
      cnt  <= cnt + {1'b0, push} - {1'b0, pop};
    end
  assign {head_err, head_instr} = mem[rptr];
endmodule

// File: rtl/qpu_ift2itcm.sv
// qpu_ift2itcm: IFU fetch bridge to single-port ITCM with fault check,
// credit-based flow control and an in-order 2-entry response buffer.
module qpu_ift2itcm
  import qpu_ift2itcm_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter int              INSTR_W   = 32,
  parameter int              ITCM_AW   = ITCM_AW_DEF,
  parameter logic [PC_W-1:0] ITCM_BASE = ITCM_BASE_DEF,
  parameter int              RD_LAT    = RD_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ifu_req_valid,
  output logic               ifu_req_ready,
  input  logic [PC_W-1:0]    ifu_req_pc,
  input  logic               ifu_req_seq,
  output logic               ifu_rsp_valid,
  input  logic               ifu_rsp_ready,
  output logic [INSTR_W-1:0] ifu_rsp_instr,
  output logic               ifu_rsp_err,
  input  logic               itcm_hold,
  output logic               itcm_cs,
  output logic [ITCM_AW-1:0] itcm_addr,
  input  logic [INSTR_W-1:0] itcm_rdata,
  output logic [PERF_W-1:0]  perf_seq_cnt,
  output logic [PERF_W-1:0]  perf_redir_cnt
);
  localparam int OFF_HI = ITCM_AW + 2;
  logic [PC_W-1:0]    off;
  logic               fault, req_hs, bypass, buf_push, buf_pop;
  logic [RD_LAT-1:0]  vld_q, err_q;
  logic [1:0]         inflight, buf_cnt;
  logic               ret_vld, ret_err, buf_err;
  logic [INSTR_W-1:0] ret_data, buf_instr;
  logic               unused_ok;
  assign off       = ifu_req_pc - ITCM_BASE;
  assign fault     = (|off[PC_W-1:OFF_HI]) | ifu_req_pc[1];
  assign unused_ok = ^{off[1:0], ifu_req_pc[0]};
  // Credits come from registered state only, so no path from ifu_rsp_ready.
  assign ifu_req_ready = ~itcm_hold & (({1'b0, inflight} + {1'b0, buf_cnt}) < 3'd2);
  assign req_hs        = ifu_req_valid & ifu_req_ready;
  assign itcm_cs       = req_hs & ~fault;
  assign itcm_addr     = off[OFF_HI-1:2];
  always_comb begin
    inflight = 2'd0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + {1'b0, vld_q[i]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_q <= '0;
      err_q <= '0;
    end else begin
      vld_q <= RD_LAT'({vld_q, req_hs});
      err_q <= RD_LAT'({err_q, fault});
    end
  assign ret_vld  = vld_q[RD_LAT-1];
  assign ret_err  = err_q[RD_LAT-1];
  assign ret_data = ret_err ? '0 : itcm_rdata;
  // Returning entry skips the buffer when it is empty; parked only if not taken.
  assign bypass        = ret_vld & (buf_cnt == 2'd0);
  assign buf_push      = ret_vld & ~(bypass & ifu_rsp_ready);
  assign buf_pop       = (buf_cnt != 2'd0) & ifu_rsp_ready;
  assign ifu_rsp_valid = (buf_cnt != 2'd0) | bypass;
  assign ifu_rsp_instr = bypass ? ret_data : buf_instr;
  assign ifu_rsp_err   = bypass ? ret_err : buf_err;
  qpu_ift2itcm_rspbuf #(.W(INSTR_W)) u_rspbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (buf_push),
    .push_err   (ret_err),
    .push_instr (ret_data),
    .pop        (buf_pop),
    .head_err   (buf_err),
    .head_instr (buf_instr),
    .cnt        (buf_cnt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_seq_cnt   <= '0;
      perf_redir_cnt <= '0;
    end else if (req_hs) begin
      if (ifu_req_seq) perf_seq_cnt <= sat_inc(perf_seq_cnt);
      else perf_redir_cnt <= sat_inc(perf_redir_cnt);
    end
endmodule

// File: tb/tb_qpu_ift2itcm.sv
// tb_qpu_ift2itcm: directed stimulus with a queue scoreboard checking responses in order
module tb_qpu_ift2itcm;
  localparam int AW = 12;
  typedef struct packed {logic err; logic [31:0] instr;} exp_t;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic          ifu_req_valid = 1'b0, ifu_req_ready, ifu_req_seq = 1'b0;
  logic [31:0]   ifu_req_pc = '0;
  logic          ifu_rsp_valid, ifu_rsp_ready = 1'b1, ifu_rsp_err;
  logic [31:0]   ifu_rsp_instr, itcm_rdata = '0;
  logic          itcm_hold = 1'b0, itcm_cs;
  logic [AW-1:0] itcm_addr;
  logic [15:0]   perf_seq_cnt, perf_redir_cnt;
  int            n_cmp = 0, n_err = 0;
  exp_t          q[$];
  logic          stall_q = 1'b0;
  logic [32:0]   held;
  always #5 clk = ~clk;
  qpu_ift2itcm dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_pc(ifu_req_pc), .ifu_req_seq(ifu_req_seq),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_err(ifu_rsp_err),
    .itcm_hold(itcm_hold), .itcm_cs(itcm_cs), .itcm_addr(itcm_addr),
    .itcm_rdata(itcm_rdata),
    .perf_seq_cnt(perf_seq_cnt), .perf_redir_cnt(perf_redir_cnt)
  );
  function automatic logic [31:0] mem_fn(input logic [AW-1:0] a);
    return (a == 12'd4) ? 32'hDEADBEEF : {20'hC0DE0, a};
  endfunction
  function automatic logic is_fault(input logic [31:0] pc);
    return (pc >= 32'h4000) | pc[1];
  endfunction
  always @(posedge clk) if (itcm_cs) itcm_rdata <= mem_fn(itcm_addr);
  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_q) chk("rsp_stable", {ifu_rsp_err, ifu_rsp_instr}, held);
      if (ifu_rsp_valid & ifu_rsp_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_unexpected: got %h expected none at %0t", ifu_rsp_instr, $time);
        end else chk("rsp", {ifu_rsp_err, ifu_rsp_instr}, q.pop_front());
      end
      stall_q = ifu_rsp_valid & ~ifu_rsp_ready;
      held    = {ifu_rsp_err, ifu_rsp_instr};
      if (ifu_req_valid & ifu_req_ready)
        q.push_back({is_fault(ifu_req_pc), is_fault(ifu_req_pc) ? 32'h0 : mem_fn(ifu_req_pc[AW+1:2])});
    end else stall_q = 1'b0;
  end
  task automatic req(input logic [31:0] pc, input logic seq);
    bit done = 0;
    ifu_req_valid = 1'b1;
    ifu_req_pc    = pc;
    ifu_req_seq   = seq;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (ifu_req_ready) begin
        done = 1;
        chk("itcm_cs", {32'h0, itcm_cs}, {32'h0, ~is_fault(pc)});
      end
    end
    if (!done) chk("req_timeout", 33'd0, 33'd1);
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    ifu_req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", {32'h0, ifu_rsp_valid}, 33'd0);
    chk("rst_rsp_err", {32'h0, ifu_rsp_err}, 33'd0);
    chk("rst_itcm_cs", {32'h0, itcm_cs}, 33'd0);
    chk("rst_perf", {1'b0, perf_seq_cnt, perf_redir_cnt}, 33'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready_after_rst", {32'h0, ifu_req_ready}, 33'd1);
    @(posedge clk); #1;
    ifu_req_valid = 1'b1; ifu_req_pc = 32'h10; ifu_req_seq = 1'b0;
    @(negedge clk);
    chk("first_cs", {32'h0, itcm_cs}, 33'd1);
    chk("first_addr", {21'h0, itcm_addr}, 33'd4);
    @(posedge clk); #1 ifu_req_valid = 1'b0;
    @(negedge clk);
    chk("first_latency", {32'h0, ifu_rsp_valid}, 33'd1);
    @(posedge clk); #1;
    req(32'h0, 1'b1); req(32'h4, 1'b1); req(32'h8, 1'b1);
    idle(3);
    ifu_rsp_ready = 1'b0;
    req(32'h20, 1'b0); req(32'h24, 1'b1);
    ifu_req_valid = 1'b0;
    @(negedge clk);
    chk("bp_req_ready_low", {32'h0, ifu_req_ready}, 33'd0);
    repeat (2) @(negedge clk);
    chk("bp_req_ready_low2", {32'h0, ifu_req_ready}, 33'd0);
    @(posedge clk); #1 ifu_rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_req_ready_popA", {32'h0, ifu_req_ready}, 33'd0);
    @(negedge clk);
    chk("bp_req_ready_back", {32'h0, ifu_req_ready}, 33'd1);
    @(posedge clk); #1;
    req(32'h4000, 1'b0); req(32'h2, 1'b0);
    idle(3);
    req(32'h30, 1'b1);
    itcm_hold = 1'b1; ifu_req_valid = 1'b1; ifu_req_pc = 32'h34;
    repeat (3) begin
      @(negedge clk);
      chk("hold_req_ready", {32'h0, ifu_req_ready}, 33'd0);
      chk("hold_cs", {32'h0, itcm_cs}, 33'd0);
    end
    @(posedge clk); #1 itcm_hold = 1'b0;
    req(32'h34, 1'b1);
    idle(3);
    ifu_rsp_ready = 1'b0;
    req(32'h40, 1'b1);
    ifu_req_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("rst_clears_valid", {32'h0, ifu_rsp_valid}, 33'd0);
    chk("rst_clears_perf", {1'b0, perf_seq_cnt, perf_redir_cnt}, 33'd0);
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1; ifu_rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_stale_rsp", {32'h0, ifu_rsp_valid}, 33'd0);
    @(posedge clk); #1;
    req(32'h0, 1'b1); req(32'h4, 1'b1); req(32'h100, 1'b0); req(32'h8, 1'b1); req(32'h200, 1'b0);
    ifu_req_valid = 1'b0;
    @(negedge clk);
    chk("perf_seq", {17'h0, perf_seq_cnt}, 33'd3);
    chk("perf_redir", {17'h0, perf_redir_cnt}, 33'd2);
    @(posedge clk); #1;
    ifu_req_valid = 1'b1; ifu_req_pc = 32'h8; ifu_req_seq = 1'b1;
    repeat (65532) @(posedge clk);
    #1 ifu_req_valid = 1'b0;
    @(negedge clk);
    chk("perf_seq_ffff", {17'h0, perf_seq_cnt}, {17'h0, 16'hFFFF});
    @(posedge clk); #1 ifu_req_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 ifu_req_valid = 1'b0;
    @(negedge clk);
    chk("perf_seq_sat", {17'h0, perf_seq_cnt}, {17'h0, 16'hFFFF});
    chk("perf_redir_kept", {17'h0, perf_redir_cnt}, 33'd2);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) chk("drain", {1'b0, 32'(q.size())}, 33'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
